// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: hunts for a sync byte, buffers a
// length-prefixed payload, verifies its additive checksum and holds good frames.
module uart_rx_frame_ctrl #(
  parameter int unsigned           DATA_W         = 8,
  parameter int unsigned           MAX_LEN        = 16,
  parameter logic [DATA_W-1:0]     SYNC_BYTE      = 8'hA5,
  parameter int unsigned           TIMEOUT_CYCLES = 27000,
  localparam int unsigned          AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              frame_valid,
  output logic [7:0]        frame_len,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_ack,
  output logic              err_len,
  output logic              err_checksum,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic              busy
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHECK,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [7:0]        frame_len_q, frame_len_d;
  logic              valid_q, valid_d;
  logic              err_len_q, err_len_d;
  logic              err_ck_q, err_ck_d;
  logic              err_to_q, err_to_d;
  logic              err_ov_q, err_ov_d;
  logic              wr_en;

  logic [DATA_W-1:0] mem [MAX_LEN];

  logic is_sync;
  logic len_bad;
  assign is_sync = (rx_data == SYNC_BYTE);
  assign len_bad = (rx_data == '0) || (rx_data > DATA_W'(MAX_LEN));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cnt_d       = '0;
    frame_len_d = frame_len_q;
    err_len_d   = 1'b0;
    err_ck_d    = 1'b0;
    err_to_d    = 1'b0;
    err_ov_d    = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_data_ready && is_sync) state_d = LEN;
      end

      LEN, PAYLOAD, CHECK: begin
        // A byte arriving on the limit cycle takes priority over the timeout.
        if (rx_data_ready) begin
          unique case (state_q)
            LEN: begin
              if (len_bad) begin
                err_len_d = 1'b1;
                state_d   = IDLE;
              end else begin
                len_d   = 8'(rx_data);
                sum_d   = rx_data;
                idx_d   = '0;
                state_d = PAYLOAD;
              end
            end
            PAYLOAD: begin
              wr_en = 1'b1;
              sum_d = sum_q + rx_data;
              idx_d = idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) state_d = CHECK;
            end
            default: begin
              if (rx_data == sum_q) begin
                frame_len_d = len_q;
                state_d     = HOLD;
              end else begin
                err_ck_d = 1'b1;
                state_d  = IDLE;
              end
            end
          endcase
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        // Ack releases the buffer; a same-cycle byte is then judged as an IDLE byte.
        if (frame_ack) begin
          state_d = (rx_data_ready && is_sync) ? LEN : IDLE;
        end else if (rx_data_ready) begin
          err_ov_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    valid_d = (state_d == HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      frame_len_q <= '0;
      valid_q     <= 1'b0;
      err_len_q   <= 1'b0;
      err_ck_q    <= 1'b0;
      err_to_q    <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      frame_len_q <= frame_len_d;
      valid_q     <= valid_d;
      err_len_q   <= err_len_d;
      err_ck_q    <= err_ck_d;
      err_to_q    <= err_to_d;
      err_ov_q    <= err_ov_d;
    end
  end

  // NOTE: the payload buffer has no reset; its contents only matter once a frame is held.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx_q[AW-1:0]] <= rx_data;
  end

  assign rd_data      = (int'(rd_addr) < MAX_LEN) ? mem[rd_addr] : '0;
  assign frame_valid  = valid_q;
  assign frame_len    = frame_len_q;
  assign err_len      = err_len_q;
  assign err_checksum = err_ck_q;
  assign err_timeout  = err_to_q;
  assign err_overrun  = err_ov_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: a queue-based frame model is compared
// against the DUT every cycle, plus literal expectations from hand-computed frames.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_data_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       frame_ack = 1'b0;
  logic       err_len, err_checksum, err_timeout, err_overrun, busy;

  uart_rx_frame_ctrl #(
    .DATA_W(8), .MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .frame_valid(frame_valid), .frame_len(frame_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_ack(frame_ack), .err_len(err_len),
    .err_checksum(err_checksum), .err_timeout(err_timeout),
    .err_overrun(err_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame collection is a queue of bytes seen since sync (length first).
  bit         m_hold, m_active;
  logic [7:0] m_q[$];
  int         m_idle;
  logic [7:0] m_mem [MAX_LEN];
  logic [7:0] e_len;
  bit         e_err_len, e_err_ck, e_err_to, e_err_ov;

  task automatic model_update(input bit r, input bit v, input logic [7:0] d, input bit a);
    int s;
    e_err_len = 0; e_err_ck = 0; e_err_to = 0; e_err_ov = 0;
    if (r) begin
      m_hold = 0; m_active = 0; m_q.delete(); m_idle = 0; e_len = 8'h00;
      return;
    end
    if (m_hold) begin
      if (a) m_hold = 0;
      else begin
        if (v) e_err_ov = 1;
        return;
      end
    end
    if (!m_active) begin
      if (v && d == SYNC) begin
        m_active = 1; m_q.delete(); m_idle = 0;
      end
      return;
    end
    if (v) begin
      m_idle = 0;
      m_q.push_back(d);
      if (m_q.size() == 1) begin
        if (d == 0 || d > MAX_LEN) begin
          e_err_len = 1; m_active = 0;
        end
      end else if (m_q.size() == int'(m_q[0]) + 2) begin
        s = 0;
        for (int i = 0; i < m_q.size() - 1; i++) s += m_q[i];
        if ((s % 256) == int'(d)) begin
          m_hold = 1; e_len = m_q[0];
        end else e_err_ck = 1;
        m_active = 0;
      end else begin
        m_mem[m_q.size() - 2] = d;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        e_err_to = 1; m_active = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("frame_valid", frame_valid, m_hold);
      check("busy", busy, m_hold || m_active);
      check("frame_len", frame_len, e_len);
      check("err_len", err_len, e_err_len);
      check("err_checksum", err_checksum, e_err_ck);
      check("err_timeout", err_timeout, e_err_to);
      check("err_overrun", err_overrun, e_err_ov);
      if (m_hold && int'(rd_addr) < int'(e_len)) check("rd_data", rd_data, m_mem[rd_addr]);
    end
  end

  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit a);
    rst           = r;
    rx_data_ready = v;
    rx_data       = v ? d : 8'($urandom);
    frame_ack     = a;
    rd_addr       = rd_addr + 4'd1;
    @(posedge clk);
    model_update(r, v, d, a);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(0, 1, b, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask

  task automatic read_at(input logic [3:0] a, input logic [7:0] exp, input string name);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  initial begin
    step(1, 0, 8'h00, 0);
    cmp_en = 1'b1;
    step(1, 0, 8'h00, 0);
    check("reset_valid", frame_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_len", frame_len, 0);

    // Noise before sync, then a good 3-byte frame.
    send(8'h00); send(8'hFF);
    check("noise_busy", busy, 0);
    send(SYNC); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
    check("pre_sum_valid", frame_valid, 0);
    send(8'h63);
    check("good_valid", frame_valid, 1);
    check("good_len", frame_len, 3);
    read_at(4'd0, 8'h10, "rd0");
    read_at(4'd1, 8'h20, "rd1");
    read_at(4'd2, 8'h30, "rd2");
    idle(3);

    // Overrun in HOLD, then ack.
    send(8'h55);
    check("overrun_pulse", err_overrun, 1);
    check("overrun_valid", frame_valid, 1);
    check("overrun_len", frame_len, 3);
    idle(1);
    check("overrun_one_cycle", err_overrun, 0);
    read_at(4'd1, 8'h20, "rd1_after_overrun");
    step(0, 0, 8'h00, 1);
    check("ack_valid", frame_valid, 0);
    check("ack_busy", busy, 0);

    // Bad checksum, then a good one-byte frame.
    send(SYNC); send(8'h02); send(8'hFF); send(8'h01); send(8'h00);
    check("ck_pulse", err_checksum, 1);
    check("ck_valid", frame_valid, 0);
    idle(1);
    check("ck_one_cycle", err_checksum, 0);
    send(SYNC); send(8'h01); send(8'h07); send(8'h08);
    check("after_ck_valid", frame_valid, 1);
    idle(2);

    // Ack and sync in the same cycle: straight to LEN, no overrun.
    step(0, 1, SYNC, 1);
    check("race_overrun", err_overrun, 0);
    check("race_valid", frame_valid, 0);
    check("race_busy", busy, 1);
    send(8'h02); send(8'h01); send(8'h01); send(8'h04);
    check("race_frame_valid", frame_valid, 1);
    step(0, 0, 8'h00, 1);

    // Length errors and the maximum length.
    send(SYNC); send(8'h00);
    check("len0_pulse", err_len, 1);
    send(SYNC); send(8'h11);
    check("len17_pulse", err_len, 1);
    send(SYNC); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h88);
    check("max_valid", frame_valid, 1);
    check("max_len", frame_len, 16);
    read_at(4'd15, 8'h0F, "rd15");
    step(0, 0, 8'h00, 1);

    // Timeout after the limit; a byte on the limit cycle wins instead.
    send(SYNC); send(8'h02); send(8'hAA);
    idle(TMO - 1);
    check("pre_timeout", err_timeout, 0);
    check("pre_timeout_busy", busy, 1);
    idle(1);
    check("timeout_pulse", err_timeout, 1);
    check("timeout_busy", busy, 0);
    idle(1);
    check("timeout_one_cycle", err_timeout, 0);
    send(SYNC); send(8'h02); send(8'hAA);
    idle(TMO - 1);
    send(8'hBB);
    check("limit_byte_no_timeout", err_timeout, 0);
    check("limit_byte_busy", busy, 1);
    idle(TMO - 1);
    send(8'h67);
    check("limit_frame_valid", frame_valid, 1);
    step(0, 0, 8'h00, 1);
    send(SYNC);
    idle(TMO);
    check("len_timeout", err_timeout, 1);

    // Sync value inside a frame is ordinary data.
    send(SYNC); send(8'h02); send(SYNC); send(SYNC); send(8'h4C);
    check("sync_data_valid", frame_valid, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    check("stray_ack_busy", busy, 0);

    // Reset mid-payload and mid-hold.
    send(SYNC); send(8'h03); send(8'h11);
    step(1, 0, 8'h00, 0);
    check("rst_payload_busy", busy, 0);
    check("rst_payload_errs", {err_len, err_checksum, err_timeout, err_overrun}, 0);
    send(SYNC); send(8'h01); send(8'h05); send(8'h06);
    check("pre_rst_hold", frame_valid, 1);
    step(1, 0, 8'h00, 0);
    check("rst_hold_valid", frame_valid, 0);
    check("rst_hold_len", frame_len, 0);
    check("rst_hold_busy", busy, 0);
    idle(2);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
